// File: rtl/restador8b_serie_if.sv
// rtl/restador8b_serie_if.sv - start/operand/result bundle for the serial 8-bit subtractor
interface restador8b_serie_if;
    logic       inicio;
    logic [7:0] a;
    logic [7:0] b;
    logic       entPrestamo;
    logic       ocupado;
    logic       listo;
    logic [7:0] dif;
    logic       salPrestamo;
    logic       desbordamiento;
    logic       cero;

    modport master (
        output inicio, a, b, entPrestamo,
        input  ocupado, listo, dif, salPrestamo, desbordamiento, cero
    );

    modport slave (
        input  inicio, a, b, entPrestamo,
        output ocupado, listo, dif, salPrestamo, desbordamiento, cero
    );
endinterface

// File: rtl/restador8b_serie.sv
// rtl/restador8b_serie.sv - bit-serial 8-bit subtractor with ripple borrow and atomic result publish
module restador8b_serie (
    input logic               reloj,
    input logic               reinicio_n,
    restador8b_serie_if.slave bus
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        RESTA  = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t    estado;
    estado_t    estado_sig;

    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] res_q;
    logic [2:0] cont;
    logic       p;

    logic       a_i;
    logic       b_i;
    logic       d;
    logic       p_sig;
    logic [7:0] res_sig;
    logic       ultimo_bit;

    logic       ocupado_q;
    logic       listo_q;
    logic [7:0] dif_q;
    logic       sal_q;
    logic       desb_q;
    logic       cero_q;

    always_comb begin
        estado_sig = estado;
        a_i        = a_q[cont];
        b_i        = b_q[cont];
        d          = a_i ^ b_i ^ p;
        p_sig      = (~a_i & b_i) | (~(a_i ^ b_i) & p);
        res_sig    = {d, res_q[7:1]};
        ultimo_bit = (cont == 3'd7);
        case (estado)
            REPOSO:  if (bus.inicio) estado_sig = RESTA;
            RESTA:   if (ultimo_bit) estado_sig = FIN;
            FIN:     estado_sig = REPOSO;
            default: estado_sig = REPOSO;
        endcase
    end

    // Status flags are registered from the next state so they are glitch-free and aligned with it.
    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            estado    <= REPOSO;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            res_q     <= 8'h00;
            cont      <= 3'd0;
            p         <= 1'b0;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
            dif_q     <= 8'h00;
            sal_q     <= 1'b0;
            desb_q    <= 1'b0;
            cero_q    <= 1'b0;
        end else begin
            estado    <= estado_sig;
            ocupado_q <= (estado_sig == RESTA);
            listo_q   <= (estado_sig == FIN);
            case (estado)
                REPOSO: begin
                    if (bus.inicio) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        p     <= bus.entPrestamo;
                        cont  <= 3'd0;
                        res_q <= 8'h00;
                    end
                end
                RESTA: begin
                    res_q <= res_sig;
                    p     <= p_sig;
                    cont  <= cont + 3'd1;
                    // Publish all result flags together on the edge that completes bit 7.
                    if (ultimo_bit) begin
                        dif_q  <= res_sig;
                        sal_q  <= p_sig;
                        desb_q <= (a_q[7] ^ b_q[7]) & (res_sig[7] ^ a_q[7]);
                        cero_q <= (res_sig == 8'h00);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ocupado        = ocupado_q;
    assign bus.listo          = listo_q;
    assign bus.dif            = dif_q;
    assign bus.salPrestamo    = sal_q;
    assign bus.desbordamiento = desb_q;
    assign bus.cero           = cero_q;

endmodule

// File: tb/tb_restador8b_serie.sv
// tb/tb_restador8b_serie.sv - self-checking bench for restador8b_serie against an arithmetic model
module tb_restador8b_serie;

    logic reloj;
    logic reinicio_n;
    int   checks;
    int   failures;

    logic [7:0] held_dif;
    logic       held_sal;
    logic       held_ovf;
    logic       held_cero;
    logic [7:0] lo_byte;
    logic [7:0] hi_byte;
    logic       lo_borrow;
    logic [15:0] combinado;

    restador8b_serie_if bus ();

    restador8b_serie dut (
        .reloj      (reloj),
        .reinicio_n (reinicio_n),
        .bus        (bus.slave)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        bus.a           = 8'($urandom);
        bus.b           = 8'($urandom);
        bus.entPrestamo = 1'($urandom);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_dif_hold"},  32'(bus.dif),            32'(held_dif));
        check({tag, "_sal_hold"},  32'(bus.salPrestamo),    32'(held_sal));
        check({tag, "_ovf_hold"},  32'(bus.desbordamiento), 32'(held_ovf));
        check({tag, "_cero_hold"}, 32'(bus.cero),           32'(held_cero));
    endtask

    // Call just after a rising edge; accepts at the next edge and runs to one edge past listo.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_in, input logic tbin,
                         input bit disturb, input string tag);
        int         full;
        int         sfull;
        logic [7:0] e_dif;
        logic       e_sal;
        logic       e_ovf;
        logic       e_cero;
        full   = int'(ta) - int'(tb_in) - int'(tbin);
        sfull  = int'($signed(ta)) - int'($signed(tb_in)) - int'(tbin);
        e_dif  = full[7:0];
        e_sal  = (full < 0);
        e_ovf  = (sfull < -128) || (sfull > 127);
        e_cero = (e_dif == 8'h00);

        bus.a           = ta;
        bus.b           = tb_in;
        bus.entPrestamo = tbin;
        bus.inicio      = 1'b1;
        @(posedge reloj); #1;
        bus.inicio = 1'b0;
        scramble_inputs();
        check({tag, "_e0_ocupado"}, 32'(bus.ocupado), 32'd1);
        check({tag, "_e0_listo"},   32'(bus.listo),   32'd0);

        for (int k = 1; k <= 7; k++) begin
            if (disturb && k == 3) bus.inicio = 1'b1;
            @(posedge reloj); #1;
            bus.inicio = 1'b0;
            if (disturb) scramble_inputs();
            check($sformatf("%s_e%0d_ocupado", tag, k), 32'(bus.ocupado), 32'd1);
            check($sformatf("%s_e%0d_listo", tag, k),   32'(bus.listo),   32'd0);
            if (k == 4 || disturb) check_held($sformatf("%s_e%0d", tag, k));
        end

        if (disturb) bus.inicio = 1'b1;
        @(posedge reloj); #1;
        bus.inicio = 1'b0;
        check({tag, "_e8_listo"},   32'(bus.listo),          32'd1);
        check({tag, "_e8_ocupado"}, 32'(bus.ocupado),        32'd0);
        check({tag, "_dif"},        32'(bus.dif),            32'(e_dif));
        check({tag, "_sal"},        32'(bus.salPrestamo),    32'(e_sal));
        check({tag, "_ovf"},        32'(bus.desbordamiento), 32'(e_ovf));
        check({tag, "_cero"},       32'(bus.cero),           32'(e_cero));
        held_dif  = e_dif;
        held_sal  = e_sal;
        held_ovf  = e_ovf;
        held_cero = e_cero;

        @(posedge reloj); #1;
        check({tag, "_e9_listo"},   32'(bus.listo),   32'd0);
        check({tag, "_e9_ocupado"}, 32'(bus.ocupado), 32'd0);
        check_held({tag, "_e9"});
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        held_dif        = 8'h00;
        held_sal        = 1'b0;
        held_ovf        = 1'b0;
        held_cero       = 1'b0;
        reinicio_n      = 1'b0;
        bus.inicio      = 1'b0;
        bus.a           = 8'h00;
        bus.b           = 8'h00;
        bus.entPrestamo = 1'b0;

        repeat (2) @(posedge reloj);
        #1;
        check("rst_ocupado", 32'(bus.ocupado), 32'd0);
        check("rst_listo",   32'(bus.listo),   32'd0);
        check_held("rst");
        @(negedge reloj);
        reinicio_n = 1'b1;
        @(posedge reloj); #1;

        do_op(8'h50, 8'h20, 1'b0, 1'b0, "t50_20");
        do_op(8'h00, 8'h01, 1'b0, 1'b0, "t00_01");
        do_op(8'h80, 8'h01, 1'b0, 1'b0, "t80_01");
        do_op(8'h05, 8'h04, 1'b1, 1'b0, "t05_04_b");
        do_op(8'hFF, 8'hFF, 1'b1, 1'b0, "tFF_FF_b");
        do_op(8'h50, 8'h20, 1'b0, 1'b1, "disturb");

        // Abort between E4 and E5, while bit 4 is being processed.
        bus.a           = 8'hA5;
        bus.b           = 8'h3C;
        bus.entPrestamo = 1'b1;
        bus.inicio      = 1'b1;
        @(posedge reloj); #1;
        bus.inicio = 1'b0;
        repeat (4) @(posedge reloj);
        #3;
        reinicio_n = 1'b0;
        #1;
        held_dif  = 8'h00;
        held_sal  = 1'b0;
        held_ovf  = 1'b0;
        held_cero = 1'b0;
        check("abort_ocupado", 32'(bus.ocupado), 32'd0);
        check("abort_listo",   32'(bus.listo),   32'd0);
        check_held("abort");
        @(negedge reloj);
        reinicio_n = 1'b1;
        @(posedge reloj); #1;
        do_op(8'h10, 8'h01, 1'b0, 1'b0, "after_rst");

        do_op(8'h00, 8'h01, 1'b0, 1'b0, "chain_lo");
        lo_byte   = bus.dif;
        lo_borrow = bus.salPrestamo;
        do_op(8'h01, 8'h00, lo_borrow, 1'b0, "chain_hi");
        hi_byte   = bus.dif;
        combinado = {hi_byte, lo_byte};
        check("chain_16b",    32'(combinado),       32'h00FF);
        check("chain_borrow", 32'(bus.salPrestamo), 32'd0);

        for (int n = 0; n < 20; n++) begin
            do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
